// File: rtl/keypad_cmd_encoder.sv
// 4x4 membrane keypad scanner and debouncer. Emits one registered command
// code pulse per accepted key press for the calculator cmd input.
module keypad_cmd_encoder #(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 8
) (
  input  logic       clock,
  input  logic       reset,
  output logic [3:0] row_n,
  input  logic [3:0] col_n,
  output logic [3:0] cmd,
  output logic       cmd_valid,
  output logic       key_held
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] SLOT_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(DEBOUNCE_SCANS);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_SCANS - 1);
  localparam logic [3:0]    NOOP      = 4'b1111;
  localparam logic [3:0]    DEAD_KEY  = 4'd15;

  typedef enum logic [1:0] {IDLE, DEBOUNCE, EMIT, HELD} state_t;

  // hits saturates at 2: anything above one contact is ghosting
  typedef struct packed {
    logic [1:0] hits;
    logic [3:0] idx;
  } scan_t;

  logic [3:0]    col_s1, col_s2;
  logic [DW-1:0] slot;
  logic [1:0]    row_idx;
  scan_t         acc, cur;
  logic          slot_end, scan_end, scan_single, scan_none;
  logic [3:0]    closed;
  logic [1:0]    row_hits;
  logic [1:0]    row_col;

  state_t        state;
  logic [3:0]    cand;
  logic [CW-1:0] cnt, rel;

  function automatic logic [3:0] keymap(input logic [3:0] idx);
    case (idx)
      4'd0:    keymap = 4'b0001;
      4'd1:    keymap = 4'b0010;
      4'd2:    keymap = 4'b0011;
      4'd3:    keymap = 4'b1010;
      4'd4:    keymap = 4'b0100;
      4'd5:    keymap = 4'b0101;
      4'd6:    keymap = 4'b0110;
      4'd7:    keymap = 4'b1011;
      4'd8:    keymap = 4'b0111;
      4'd9:    keymap = 4'b1000;
      4'd10:   keymap = 4'b1001;
      4'd11:   keymap = 4'b1100;
      4'd12:   keymap = 4'b1101;
      4'd13:   keymap = 4'b0000;
      4'd14:   keymap = 4'b1110;
      default: keymap = NOOP;
    endcase
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      col_s1 <= 4'b1111;
      col_s2 <= 4'b1111;
    end else begin
      col_s1 <= col_n;
      col_s2 <= col_s1;
    end
  end

  assign closed      = ~col_s2;
  assign slot_end    = (slot == SLOT_LAST);
  assign scan_end    = slot_end && (row_idx == 2'd3);
  assign scan_single = scan_end && (cur.hits == 2'd1);
  assign scan_none   = scan_end && (cur.hits == 2'd0);

  // lowest closed column wins the index; only meaningful when exactly one hit
  always_comb begin
    row_hits = 2'd0;
    row_col  = 2'd0;
    for (int c = 3; c >= 0; c--) begin
      if (closed[c]) begin
        row_col  = 2'(c);
        row_hits = (row_hits == 2'd0) ? 2'd1 : 2'd2;
      end
    end
  end

  always_comb begin
    cur = acc;
    if (acc.hits == 2'd0) begin
      cur.hits = row_hits;
      cur.idx  = {row_idx, row_col};
    end else if (row_hits != 2'd0) begin
      cur.hits = 2'd2;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      slot    <= '0;
      row_idx <= 2'd0;
      row_n   <= 4'b1110;
      acc     <= '0;
    end else if (slot_end) begin
      slot    <= '0;
      row_idx <= row_idx + 2'd1;
      row_n   <= {row_n[2:0], row_n[3]};
      acc     <= scan_end ? scan_t'('0) : cur;
    end else begin
      slot <= slot + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cand      <= 4'd0;
      cnt       <= '0;
      rel       <= '0;
      cmd       <= NOOP;
      cmd_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (scan_single) begin
            cand  <= cur.idx;
            cnt   <= CW'(1);
            state <= DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (scan_end) begin
            if (scan_single && cur.idx == cand) begin
              if (cnt == CNT_LAST) begin
                cnt       <= CNT_MAX;
                state     <= EMIT;
                key_held  <= 1'b1;
                cmd       <= keymap(cand);
                cmd_valid <= (cand != DEAD_KEY);
              end else begin
                cnt <= cnt + 1'b1;
              end
            end else begin
              cnt   <= '0;
              state <= IDLE;
            end
          end
        end
        EMIT: begin
          cmd       <= NOOP;
          cmd_valid <= 1'b0;
          cnt       <= '0;
          rel       <= '0;
          state     <= HELD;
        end
        HELD: begin
          if (scan_end) begin
            if (scan_none) begin
              if (rel == CNT_LAST) begin
                rel      <= '0;
                key_held <= 1'b0;
                state    <= IDLE;
              end else begin
                rel <= rel + 1'b1;
              end
            end else begin
              rel <= '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_cmd_encoder.sv
// Directed bench for keypad_cmd_encoder with SCAN_DIV=4, DEBOUNCE_SCANS=3
// (16-cycle scan). Cycle numbers count rising edges since reset release.
module tb_keypad_cmd_encoder;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] row_n, col_n, cmd;
  logic       cmd_valid, key_held;

  logic [3:0][3:0] key = '0;  // key[row][col]
  int         cyc;
  int         nvec = 0;
  int         nerr = 0;
  int         bad_idle = 0;
  logic [3:0] pq[$];
  int         pc[$];

  keypad_cmd_encoder #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
    .clock(clock), .reset(reset), .row_n(row_n), .col_n(col_n),
    .cmd(cmd), .cmd_valid(cmd_valid), .key_held(key_held)
  );

  always #5 clock = ~clock;

  // a closed key shorts its row to its column
  always_comb begin
    col_n = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (key[r][c] && !row_n[r]) col_n[c] = 1'b0;
  end

  always @(posedge clock or posedge reset)
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;

  always @(negedge clock) begin
    if (!reset && cmd_valid) begin
      pq.push_back(cmd);
      pc.push_back(cyc);
    end
    if (!reset && !cmd_valid && cmd !== 4'b1111) bad_idle++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    int guard = 0;
    while (cyc != n && guard < 5000) begin
      @(negedge clock);
      guard++;
    end
    if (cyc != n) chk("wait_timeout", cyc, n);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    pq.delete();
    pc.delete();
  endtask

  task automatic chk_pulse(input int i, input logic [3:0] code, input int at);
    if (pq.size() > i) begin
      chk($sformatf("pulse%0d_code", i), pq[i], code);
      if (at >= 0) chk($sformatf("pulse%0d_cyc", i), pc[i], at);
    end else begin
      chk($sformatf("pulse%0d_missing", i), pq.size(), i + 1);
    end
  endtask

  logic [3:0] seq_code [8] = '{4'b0001, 4'b1010, 4'b0001, 4'b1110,
                               4'b0011, 4'b1011, 4'b0010, 4'b1110};
  int         seq_r    [8] = '{0, 0, 0, 3, 0, 1, 0, 3};
  int         seq_c    [8] = '{0, 3, 0, 2, 2, 3, 1, 2};

  initial begin
    // reset values
    @(negedge clock);
    chk("rst_row_n", row_n, 4'b1110);
    chk("rst_cmd", cmd, 4'b1111);
    chk("rst_valid", cmd_valid, 1'b0);
    chk("rst_held", key_held, 1'b0);

    // clean press of r0c0
    key[0][0] = 1'b1;
    do_reset();
    chk("row0", row_n, 4'b1110);
    wait_cyc(4);  chk("row1", row_n, 4'b1101);
    wait_cyc(8);  chk("row2", row_n, 4'b1011);
    wait_cyc(12); chk("row3", row_n, 4'b0111);
    wait_cyc(16); chk("row_wrap", row_n, 4'b1110);
    wait_cyc(47); chk("pre_valid", cmd_valid, 1'b0); chk("pre_held", key_held, 1'b0);
    wait_cyc(48); chk("emit_valid", cmd_valid, 1'b1); chk("emit_cmd", cmd, 4'b0001);
                  chk("emit_held", key_held, 1'b1);
    wait_cyc(49); chk("post_valid", cmd_valid, 1'b0); chk("post_cmd", cmd, 4'b1111);
    wait_cyc(160); key[0][0] = 1'b0;
    wait_cyc(207); chk("held_before_rel", key_held, 1'b1);
    wait_cyc(208); chk("held_after_rel", key_held, 1'b0);
    wait_cyc(240);
    chk("clean_npulse", pq.size(), 1);
    chk_pulse(0, 4'b0001, 48);

    // "1 + 1 =" then "3 - 2 ="
    key = '0;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      key[seq_r[k]][seq_c[k]] = 1'b1;
      wait_cyc(160 * k + 80);
      key = '0;
      wait_cyc(160 * k + 160);
    end
    chk("seq_npulse", pq.size(), 8);
    for (int k = 0; k < 8; k++) chk_pulse(k, seq_code[k], 160 * k + 48);
    chk("seq_held_end", key_held, 1'b0);

    // bounce on r1c1 for two scans, then stable
    key = '0;
    do_reset();
    for (int j = 0; j < 32; j++) begin
      key[1][1] = ((j / 3) % 2 == 0);
      @(negedge clock);
    end
    key[1][1] = 1'b1;
    wait_cyc(79); chk("bounce_quiet", pq.size(), 0);
    wait_cyc(100);
    chk("bounce_npulse", pq.size(), 1);
    chk_pulse(0, 4'b0101, 80);

    // ghosting: r0c0 + r1c1, then r1c1 released
    key = '0;
    key[0][0] = 1'b1;
    key[1][1] = 1'b1;
    do_reset();
    wait_cyc(96);
    chk("ghost_held", key_held, 1'b0);
    chk("ghost_npulse", pq.size(), 0);
    key[1][1] = 1'b0;
    wait_cyc(160);
    chk("ghost_after_npulse", pq.size(), 1);
    chk_pulse(0, 4'b0001, 144);
    chk("ghost_after_held", key_held, 1'b1);

    // dead key r3c3
    key = '0;
    key[3][3] = 1'b1;
    do_reset();
    wait_cyc(47); chk("dead_held_pre", key_held, 1'b0);
    wait_cyc(48); chk("dead_held_rise", key_held, 1'b1); chk("dead_cmd", cmd, 4'b1111);
    wait_cyc(80); key[3][3] = 1'b0;
    wait_cyc(127); chk("dead_held_hold", key_held, 1'b1);
    wait_cyc(128); chk("dead_held_fall", key_held, 1'b0);
    chk("dead_npulse", pq.size(), 0);

    // reset mid-debounce with r2c2 kept pressed
    key = '0;
    key[2][2] = 1'b1;
    do_reset();
    wait_cyc(40);
    chk("mid_held_before", key_held, 1'b0);
    reset = 1'b1;
    #1;
    chk("mid_row_n", row_n, 4'b1110);
    chk("mid_cmd", cmd, 4'b1111);
    chk("mid_valid", cmd_valid, 1'b0);
    chk("mid_held", key_held, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    wait_cyc(47); chk("mid_npulse_pre", pq.size(), 0);
    wait_cyc(60);
    chk("mid_npulse", pq.size(), 1);
    chk_pulse(0, 4'b1001, 48);
    key = '0;

    chk("idle_cmd_noop", bad_idle, 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/keypad_cmd_encoder.md
Name: keypad_cmd_encoder

Overview:
- Front end that produces the 4-bit `cmd` stream consumed by the calculator top.
- Scans a 4x4 membrane keypad (active-low rows driven, active-low columns read) and debounces it.
- Emits exactly one command code per physical key press, as a single-cycle pulse.
- Sits between the board keypad pins and the calculator `cmd` input; replaces the bench-driven `cmd`.

Parameters:
- SCAN_DIV, 1000, clock cycles each row is driven low (range 4 to 65535).
- DEBOUNCE_SCANS, 8, consecutive identical full scans needed for press detection; same count of empty scans needed for release (range 2 to 255).

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- row_n  out 4  keypad row drive; exactly one bit low at a time
- col_n  in  4  keypad column sense; pulled up, low = key closed; asynchronous to clock
- cmd  out 4  command code; 4'b1111 (no-op) except during the emit cycle
- cmd_valid  out 1  high for exactly one cycle, coincident with the code on `cmd`
- key_held  out 1  high from the emit cycle until the release is accepted

Behaviour:
- Reset values:
  - row_n=4'b1110
  - cmd=4'b1111
  - cmd_valid=0
  - key_held=0
  - slot counter=0, row index=0
  - FSM=IDLE, debounce/release counters=0
- Input sync: col_n passes through a 2-flop synchronizer; all logic uses the synchronized value.
- Scan order:
  - row_n steps 1110 -> 1101 -> 1011 -> 0111 -> wrap.
  - Each row is held for SCAN_DIV cycles.
  - Columns are sampled on the last cycle of each row slot.
  - One full scan = 4*SCAN_DIV cycles.
  - Scanning never stops, including while emitting or holding.
- Scan result (evaluated at scan end, the last cycle of the row-3 slot):
  - NONE: no closed contacts.
  - SINGLE(idx): exactly one closed contact; idx = 4*row + col, col0 = col_n[0].
  - MULTI: more than one closed contact anywhere in the scan; treated as ghosting.
- Key map (row: col0 col1 col2 col3):
  - r0: 0001, 0010, 0011, 1010(+)
  - r1: 0100, 0101, 0110, 1011(-)
  - r2: 0111, 1000, 1001, 1100(*)
  - r3: 1101(clear), 0000, 1110(=), dead key
- FSM states: IDLE, DEBOUNCE, EMIT, HELD. Transitions are evaluated only at scan end, except EMIT.
  - IDLE: SINGLE(idx) -> DEBOUNCE with cand=idx, cnt=1. NONE or MULTI -> stay.
  - DEBOUNCE: SINGLE(cand) -> cnt+1; when cnt reaches DEBOUNCE_SCANS -> EMIT. SINGLE(other), NONE or MULTI -> IDLE, cnt=0 (no restart on the new key until the next scan).
  - EMIT: lasts exactly one clock cycle; cmd=map(cand), cmd_valid=1, key_held=1; next state HELD.
    - Dead key (r3 c3): cmd stays 1111 and cmd_valid stays 0, but key_held still rises and HELD is still entered.
  - HELD: NONE -> rel+1; when rel reaches DEBOUNCE_SCANS -> IDLE, key_held=0. SINGLE or MULTI -> rel=0.
    - No auto-repeat.
    - A second key pressed while holding produces nothing until full release.
- Latency: cmd_valid asserts on the cycle immediately after the scan end where cnt reaches DEBOUNCE_SCANS.
- Outputs are registered and glitch-free; cmd returns to 1111 the cycle after EMIT.
- Reset mid-operation (any state, any cycle): immediate return to the reset values. A key still held after reset release must be debounced afresh and produces a new command.
- Counter widths: sized from the parameters; no wrap is possible because counters saturate at DEBOUNCE_SCANS.

Test Plan:
All scenarios use SCAN_DIV=4 and DEBOUNCE_SCANS=3 (scan = 16 cycles). The keypad model shorts a row to a column.
- Clean press of r0c0, held 10 scans -> after reset, row_n cycles 1110/1101/1011/0111 every 4 cycles; a single cmd=0001 with cmd_valid=1 for one cycle, on the cycle after the 3rd matching scan end; key_held=1 until 3 empty scans after release; no second pulse.
- Sequence "1 + 1 =" then "3 - 2 =" (r0c0, r0c3, r0c0, r3c2, r0c2, r1c3, r0c1, r3c2), each press 5 scans and each gap 5 scans -> cmd_valid pulses carrying 0001, 1010, 0001, 1110, 0011, 1011, 0010, 1110 in order, one pulse each.
- Bounce: r1c1 contact toggling every 3 cycles for 2 scans, then stable -> no pulse during bounce; exactly one 0101 pulse, 3 scans after it becomes stable.
- Ghosting: r0c0 and r1c1 closed together for 6 scans -> no pulse, key_held stays 0. Then release r1c1 -> one 0001 pulse after 3 scans.
- Dead key r3c3 held 5 scans -> cmd_valid never asserts, key_held rises then falls 3 empty scans after release.
- Reset asserted for 1 cycle after the 2nd matching scan of r2c2 (key kept pressed) -> all outputs return to reset values the same cycle; the first 1001 pulse arrives 3 full scans after reset deasserts.
